gmii_phy_rx_source: RTL
=======================

Name: gmii_phy_rx_source

Overview:
- PHY-side GMII/MII frame generator: the far end of the MAC receive path.
- Takes an AXI-stream payload and drives gmii_rxd/rx_dv/rx_er as a link-partner PHY would: preamble, SFD, payload, optional pad, FCS, then inter-frame gap.
- Used in loopback and simulation harnesses feeding eth_mac_1g's receiver. Supports 1000M byte mode and 10/100M nibble mode paced by a clock enable.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD (1..15).
- ENABLE_FCS, 1, append a 4-byte CRC32 FCS.
- ENABLE_PADDING, 1, zero-pad payload to MIN_FRAME_LENGTH-4 bytes.
- MIN_FRAME_LENGTH, 64, minimum frame length including FCS.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  Reset: asynchronous, active-low. Single clock domain.
- clk_en  in  1  symbol-slot enable; tie high for 1000M, pulse for 10/100M pacing.
- mii_select  in  1  1 = MII nibble mode; sampled at frame start.
- ifg_delay  in  8  gap in byte times; sampled at frame start; 0 is treated as 1.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload byte consumed this cycle.
- s_axis_tlast  in  1  last payload byte.
- s_axis_tuser  in  1  on the tlast beat: corrupt the FCS.
- gmii_rxd  out  8  PHY receive data; in MII mode only [3:0] is used and [7:4]=0.
- gmii_rx_dv  out  1  receive data valid.
- gmii_rx_er  out  1  receive error.
- busy  out  1  high from leaving IDLE until the IFG ends.

Behaviour:
- Reset values: gmii_rxd=0, rx_dv=0, rx_er=0, tready=0, busy=0, state IDLE, CRC=0xFFFFFFFF.
- gmii_* outputs are registered and update only in cycles with clk_en=1. When clk_en=0, all state and outputs hold and tready=0.
- Byte time:
  - GMII: one enabled slot per byte.
  - MII: two enabled slots per byte, low nibble first.
- State machine: IDLE -> PREAMBLE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
- IDLE:
  - Enabled cycle with tvalid=1: latch mii_select and ifg_delay, go to PREAMBLE.
  - First 0x55 appears on the outputs the following clock.
- PREAMBLE: emit PREAMBLE_LEN bytes of 0x55 with dv=1.
- SFD: emit 0xD5 with dv=1.
- Byte loading and tready:
  - tready is combinational. It is 1 only on the enabled cycle that is the final slot of the SFD byte or of a non-last payload byte.
  - tvalid=1 on that cycle: the byte is loaded, CRC and the 16-bit saturating byte counter update.
  - tvalid=0 on that cycle (underflow): emit one byte time with dv=1, er=1, rxd=0, skip PAD/FCS, go to IFG.
- DATA: emit loaded bytes. After the tlast byte:
  - If ENABLE_PADDING and count < MIN_FRAME_LENGTH-4, go to PAD.
  - Otherwise, if ENABLE_FCS, go to FCS.
  - Otherwise, go to IFG.
- PAD: emit 0x00 until count = MIN_FRAME_LENGTH-4. Pad bytes enter the CRC.
- FCS:
  - Emit ~CRC, least-significant byte first.
  - If tuser was set on the tlast beat, emit CRC un-inverted instead, which guarantees a bad FCS.
- IFG: dv=0, er=0, rxd=0 for ifg_delay byte times, then IDLE. tready=0 throughout.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, one byte per step.
- mii_select or ifg_delay changes mid-frame have no effect until the next IDLE.
- Reset mid-frame: outputs drop to reset values immediately. The partial frame is abandoned; the payload source is not drained.

Decomposition:
- Package eth_pkg:
  - state enum;
  - constants ETH_PREAMBLE_BYTE=0x55, ETH_SFD_BYTE=0xD5, CRC32_POLY=0xEDB88320, CRC32_INIT=0xFFFFFFFF.
- Sub-module eth_crc32_byte: combinational next-CRC from (crc_in[31:0], data[7:0]).

Test Plan:
1. GMII, clk_en=1, ENABLE_PADDING=0, payload ASCII "123456789" -> 7×0x55, 0xD5, 31..39, FCS 0x26 0x39 0xF4 0xCB. dv high for 21 consecutive cycles, then dv=0 for ifg_delay=12 cycles.
2. Default params, 10-byte payload 0x00..0x09 -> 50 pad bytes of 0x00. dv high for 72 byte times. FCS matches CRC32 over the 60 bytes.
3. MII mode, clk_en every 10th cycle, payload 0xA5 (padding off) -> preamble nibbles are 14×0x5 then 0x5, 0xD. The payload gives nibble 0x5 then 0xA on successive enabled cycles. gmii_rxd[7:4]=0 throughout.
4. 40-byte payload with tvalid dropped at byte 20 -> after byte 19, one byte time with dv=1, er=1. No FCS. dv falls, busy clears after the IFG.
5. "123456789" with tuser=1 on the tlast beat, padding off -> FCS bytes 0xD9 0xC6 0x0B 0x34.
6. rst_n asserted during DATA -> rxd, dv and er go to 0 without waiting for a clock edge. After release, the next frame's preamble starts cleanly and its FCS is correct.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the PHY-side frame generator state encoding.
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG,
      ST_ERR
   } state_t;

   localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC32_POLY        = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected IEEE 802.3 CRC32 (LSB-first, no final inversion).
module eth_crc32_byte
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      crc_out = c;
   end

endmodule

// File: rtl/gmii_phy_rx_source.sv
// Link-partner PHY model: turns an AXI-stream payload into a GMII/MII receive frame
// (preamble, SFD, payload, pad, FCS, gap), paced by clk_en for 10/100M.
module gmii_phy_rx_source
   import eth_pkg::*;
#(
   parameter int PREAMBLE_LEN     = 7,
   parameter int ENABLE_FCS       = 1,
   parameter int ENABLE_PADDING   = 1,
   parameter int MIN_FRAME_LENGTH = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   input  logic       mii_select,
   input  logic [7:0] ifg_delay,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] gmii_rxd,
   output logic       gmii_rx_dv,
   output logic       gmii_rx_er,
   output logic       busy
);

   localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LENGTH - 4);

   state_t      state, nx_state;
   logic        mii, half, last, bad_fcs;
   logic [7:0]  ifg, cnt, nx_cnt, cur, nx_byte;
   logic [15:0] count;
   logic [31:0] crc, crc_nx, fcs_word;
   logic [1:0]  fidx;
   logic        fin, tail, nx_er, do_load, do_pad;

   // A byte completes on every enabled slot in GMII, every second one in MII.
   assign fin           = clk_en && (!mii || half);
   assign s_axis_tready = fin && ((state == ST_SFD) || (state == ST_DATA && !last));
   assign tail          = (state == ST_DATA && last) || (state == ST_PAD);
   assign fcs_word      = bad_fcs ? crc : ~crc;
   assign fidx          = cnt[1:0] + 2'd1;
   assign busy          = (state != ST_IDLE);

   eth_crc32_byte u_crc (
      .crc_in  (crc),
      .data    (s_axis_tready ? s_axis_tdata : 8'h00),
      .crc_out (crc_nx)
   );

   always_comb begin
      nx_state = state;
      nx_cnt   = cnt;
      nx_byte  = cur;
      nx_er    = 1'b0;
      do_load  = 1'b0;
      do_pad   = 1'b0;
      if (tail) begin
         if (ENABLE_PADDING != 0 && count < PAD_TARGET) begin
            nx_state = ST_PAD;
            nx_byte  = 8'h00;
            do_pad   = 1'b1;
         end else if (ENABLE_FCS != 0) begin
            nx_state = ST_FCS;
            nx_cnt   = 8'd0;
            nx_byte  = fcs_word[7:0];
         end else begin
            nx_state = ST_IFG;
            nx_cnt   = 8'd1;
            nx_byte  = 8'h00;
         end
      end else begin
         case (state)
            ST_PREAMBLE:
               if (cnt >= 8'(PREAMBLE_LEN)) begin
                  nx_state = ST_SFD;
                  nx_byte  = ETH_SFD_BYTE;
               end else begin
                  nx_cnt   = cnt + 8'd1;
                  nx_byte  = ETH_PREAMBLE_BYTE;
               end
            ST_SFD, ST_DATA:
               if (s_axis_tvalid) begin
                  nx_state = ST_DATA;
                  nx_byte  = s_axis_tdata;
                  do_load  = 1'b1;
               end else begin
                  // source underflow: one errored byte, frame is cut short
                  nx_state = ST_ERR;
                  nx_byte  = 8'h00;
                  nx_er    = 1'b1;
               end
            ST_FCS:
               if (cnt[1:0] == 2'd3) begin
                  nx_state = ST_IFG;
                  nx_cnt   = 8'd1;
                  nx_byte  = 8'h00;
               end else begin
                  nx_cnt   = cnt + 8'd1;
                  nx_byte  = fcs_word[{fidx, 3'b000} +: 8];
               end
            ST_ERR: begin
               nx_state = ST_IFG;
               nx_cnt   = 8'd1;
               nx_byte  = 8'h00;
            end
            ST_IFG:
               if (cnt >= ifg) nx_state = ST_IDLE;
               else            nx_cnt   = cnt + 8'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         mii        <= 1'b0;
         half       <= 1'b0;
         ifg        <= 8'd1;
         cnt        <= 8'd0;
         cur        <= 8'h00;
         crc        <= CRC32_INIT;
         count      <= 16'd0;
         last       <= 1'b0;
         bad_fcs    <= 1'b0;
         gmii_rxd   <= 8'h00;
         gmii_rx_dv <= 1'b0;
         gmii_rx_er <= 1'b0;
      end else if (clk_en) begin
         if (state == ST_IDLE) begin
            if (s_axis_tvalid) begin
               state      <= ST_PREAMBLE;
               mii        <= mii_select;
               ifg        <= (ifg_delay == 8'd0) ? 8'd1 : ifg_delay;
               half       <= 1'b0;
               cnt        <= 8'd1;
               cur        <= ETH_PREAMBLE_BYTE;
               crc        <= CRC32_INIT;
               count      <= 16'd0;
               last       <= 1'b0;
               bad_fcs    <= 1'b0;
               gmii_rxd   <= mii_select ? {4'h0, ETH_PREAMBLE_BYTE[3:0]} : ETH_PREAMBLE_BYTE;
               gmii_rx_dv <= 1'b1;
               gmii_rx_er <= 1'b0;
            end
         end else if (mii && !half) begin
            half     <= 1'b1;
            gmii_rxd <= {4'h0, cur[7:4]};
         end else begin
            half       <= 1'b0;
            state      <= nx_state;
            cnt        <= nx_cnt;
            cur        <= nx_byte;
            gmii_rxd   <= mii ? {4'h0, nx_byte[3:0]} : nx_byte;
            gmii_rx_dv <= (nx_state != ST_IFG) && (nx_state != ST_IDLE);
            gmii_rx_er <= nx_er;
            if (do_load || do_pad) begin
               crc   <= crc_nx;
               count <= (&count) ? count : count + 16'd1;
            end
            if (do_load) begin
               last    <= s_axis_tlast;
               bad_fcs <= s_axis_tlast && s_axis_tuser;
            end
         end
      end
   end

endmodule
